// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD up/down counter.
// BCD_SEG7_DECODE_EN: when defined, the top adds a registered seven-segment output.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Segment order abcdefg, segment a in bit 6.
  localparam logic [6:0] SEG7_0 = 7'b1111110;
  localparam logic [6:0] SEG7_1 = 7'b0110000;
  localparam logic [6:0] SEG7_2 = 7'b1101101;
  localparam logic [6:0] SEG7_3 = 7'b1111001;
  localparam logic [6:0] SEG7_4 = 7'b0110011;
  localparam logic [6:0] SEG7_5 = 7'b1011011;
  localparam logic [6:0] SEG7_6 = 7'b1011111;
  localparam logic [6:0] SEG7_7 = 7'b1110000;
  localparam logic [6:0] SEG7_8 = 7'b1111111;
  localparam logic [6:0] SEG7_9 = 7'b1111011;

  function automatic logic [6:0] seg7_encode(input bcd_digit_t d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_0;  // digits never hold A-F
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with carry/borrow chaining to the next digit.
// BCD_SEG7_DECODE_EN: when defined, also exposes the next-state value for the decoder.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clearn,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_val,
  output logic       step_out,
  output bcd_digit_t digit
`ifdef BCD_SEG7_DECODE_EN
  ,
  output bcd_digit_t digit_nxt
`endif
);

  bcd_digit_t digit_q, digit_d;

  // Next digit: load (sanitised) beats a step; steps wrap 9<->0.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = (load_val > BCD_MAX) ? BCD_MIN : load_val;
    end else if (step_in) begin
      if (up) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else    digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Digit register, synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clearn) digit_q <= BCD_MIN;
    else         digit_q <= digit_d;
  end

  // Carry/borrow out only when this digit wraps on a step.
  always_comb begin
    step_out = step_in & (up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
  end

  assign digit = digit_q;
`ifdef BCD_SEG7_DECODE_EN
  assign digit_nxt = digit_d;
`endif

endmodule

// File: rtl/bcd_updown_counter.sv
// Prescaled, loadable, cascaded BCD up/down counter.
// BCD_SEG7_DECODE_EN: when defined, adds registered seven-segment output LEDS.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 13500
) (
  input  logic                  Clock,
  input  logic                  Clearn,
  input  logic                  E,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  Tick,
  output logic                  TC,
  output logic                  Wrap
`ifdef BCD_SEG7_DECODE_EN
  ,
  output logic [7*DIGITS-1:0]   LEDS
`endif
);

  localparam logic [15:0] PreLast = 16'(PRESCALE - 1);

  logic [15:0]   pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          wrap_q;
  logic [DIGITS:0] step;
  logic          all_max, all_min;

  // Prescaler next state; a load restarts the period from zero.
  always_comb begin
    pre_d  = (pre_q == PreLast) ? 16'd0 : pre_q + 16'd1;
    tick_d = (pre_q == PreLast);
    if (Load) begin
      pre_d  = 16'd0;
      tick_d = (PRESCALE == 1);
    end
  end

  // Prescaler, tick and wrap registers.
  always_ff @(posedge Clock) begin
    if (!Clearn) begin
      pre_q  <= 16'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      wrap_q <= step[DIGITS];
    end
  end

  // Step enters digit 0; carry/borrow ripples up the chain. Load suppresses the step.
  assign step[0] = tick_q & E & ~Load;

`ifdef BCD_SEG7_DECODE_EN
  logic [4*DIGITS-1:0] digit_nxt;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (Clock),
      .clearn   (Clearn),
      .step_in  (step[i]),
      .up       (Up),
      .load     (Load),
      .load_val (LoadVal[4*i +: 4]),
      .step_out (step[i+1]),
      .digit    (BCD[4*i +: 4])
`ifdef BCD_SEG7_DECODE_EN
      ,
      .digit_nxt(digit_nxt[4*i +: 4])
`endif
    );
  end

  // Terminal count: the next step in the current direction would wrap.
  always_comb begin
    all_max = 1'b1;
    all_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD[4*i +: 4] != BCD_MAX) all_max = 1'b0;
      if (BCD[4*i +: 4] != BCD_MIN) all_min = 1'b0;
    end
    TC = E & (Up ? all_max : all_min);
  end

  assign Tick = tick_q;
  assign Wrap = wrap_q;

`ifdef BCD_SEG7_DECODE_EN
  logic [7*DIGITS-1:0] leds_q, leds_d;

  // Decode the digits' next values so LEDS updates on the same edge as BCD.
  always_comb begin
    leds_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      leds_d[7*i +: 7] = seg7_encode(digit_nxt[4*i +: 4]);
    end
  end

  // Segment register, clears to the pattern for 0.
  always_ff @(posedge Clock) begin
    if (!Clearn) leds_q <= {DIGITS{SEG7_0}};
    else         leds_q <= leds_d;
  end

  assign LEDS = leds_q;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS=4, PRESCALE=2).
// BCD_SEG7_DECODE_EN: when defined, LEDS is connected and checked.
module tb_bcd_updown_counter;

  logic        Clock;
  logic        Clearn;
  logic        E;
  logic        Up;
  logic        Load;
  logic [15:0] LoadVal;
  logic [15:0] BCD;
  logic        Tick;
  logic        TC;
  logic        Wrap;
`ifdef BCD_SEG7_DECODE_EN
  logic [27:0] LEDS;
`endif

  int tests = 0;
  int fails = 0;

  bcd_updown_counter #(
    .DIGITS  (4),
    .PRESCALE(2)
  ) dut (
    .Clock  (Clock),
    .Clearn (Clearn),
    .E      (E),
    .Up     (Up),
    .Load   (Load),
    .LoadVal(LoadVal),
    .BCD    (BCD),
    .Tick   (Tick),
    .TC     (TC),
    .Wrap   (Wrap)
`ifdef BCD_SEG7_DECODE_EN
    ,
    .LEDS   (LEDS)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle before sampling or driving.
  task automatic tick_clk();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    Load    = 1'b1;
    LoadVal = v;
    tick_clk();
    Load    = 1'b0;
  endtask

  // Run until Tick is sampled high, bounded.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (Tick !== 1'b1 && n < 10) begin
      tick_clk();
      n++;
    end
    check(tag, {31'd0, Tick}, 32'd1);
  endtask

  initial begin
    int ticks;
    int n;

    Clearn = 1'b0; E = 1'b0; Up = 1'b1; Load = 1'b0; LoadVal = 16'h0000;
    tick_clk();
    tick_clk();
    check("reset_bcd", {16'd0, BCD}, 32'h0000);
    check("reset_tick", {31'd0, Tick}, 32'd0);
    check("reset_wrap", {31'd0, Wrap}, 32'd0);
    check("reset_tc_e0", {31'd0, TC}, 32'd0);
`ifdef BCD_SEG7_DECODE_EN
    check("reset_leds", {4'd0, LEDS}, {4'd0, {4{7'b1111110}}});
`endif
    E = 1'b1; Up = 1'b0; #1;
    check("tc_down_at_zero", {31'd0, TC}, 32'd1);
    Up = 1'b1; #1;
    check("tc_up_at_zero", {31'd0, TC}, 32'd0);

    // Up count: 20 steps from reset; steps land on every second edge.
    Clearn = 1'b1;
    ticks = 0;
    for (int i = 0; i < 41; i++) begin
      tick_clk();
      if (i == 0) check("first_tick_low", {31'd0, Tick}, 32'd0);
      if (i == 1) check("first_tick_high", {31'd0, Tick}, 32'd1);
      if (Tick === 1'b1) ticks++;
    end
    check("up_tick_count", ticks, 20);
    check("up_count_20", {16'd0, BCD}, 32'h0020);

    // Carry across two digits.
    do_load(16'h0199);
    wait_tick("carry_wait");
    tick_clk();
    check("carry_0199", {16'd0, BCD}, 32'h0200);
    check("carry_no_wrap", {31'd0, Wrap}, 32'd0);

    // Borrow across three digits.
    Up = 1'b0;
    do_load(16'h1000);
    wait_tick("borrow_wait");
    tick_clk();
    check("borrow_1000", {16'd0, BCD}, 32'h0999);

    // Up wrap.
    Up = 1'b1;
    do_load(16'h9999);
    check("tc_9999_up", {31'd0, TC}, 32'd1);
    wait_tick("upwrap_wait");
    check("upwrap_pre", {16'd0, BCD}, 32'h9999);
    tick_clk();
    check("upwrap_bcd", {16'd0, BCD}, 32'h0000);
    check("upwrap_pulse", {31'd0, Wrap}, 32'd1);
    tick_clk();
    check("upwrap_end", {31'd0, Wrap}, 32'd0);

    // Down wrap.
    Up = 1'b0;
    do_load(16'h0000);
    check("tc_0000_down", {31'd0, TC}, 32'd1);
    wait_tick("dnwrap_wait");
    tick_clk();
    check("dnwrap_bcd", {16'd0, BCD}, 32'h9999);
    check("dnwrap_pulse", {31'd0, Wrap}, 32'd1);
    tick_clk();
    check("dnwrap_end", {31'd0, Wrap}, 32'd0);

    // Load sanitising in a Tick cycle: load wins, prescaler restarts.
    wait_tick("sanit_wait");
    Load = 1'b1; LoadVal = 16'h3AF7;
    tick_clk();
    Load = 1'b0; E = 1'b0;
    check("sanit_bcd", {16'd0, BCD}, 32'h3007);
    check("sanit_tick0", {31'd0, Tick}, 32'd0);
    check("sanit_wrap", {31'd0, Wrap}, 32'd0);
    tick_clk();
    check("sanit_tick1", {31'd0, Tick}, 32'd0);
    tick_clk();
    check("sanit_tick2", {31'd0, Tick}, 32'd1);
    check("sanit_hold", {16'd0, BCD}, 32'h3007);

    // Reset mid-count while Tick is high.
    E = 1'b1; Up = 1'b1;
    do_load(16'h0458);
    wait_tick("rst_wait");
    check("rst_pre_bcd", {16'd0, BCD}, 32'h0458);
    Clearn = 1'b0;
    tick_clk();
    check("rst_bcd", {16'd0, BCD}, 32'h0000);
    check("rst_tick", {31'd0, Tick}, 32'd0);
    Clearn = 1'b1;
    tick_clk();
    check("rel_tick0", {31'd0, Tick}, 32'd0);
    tick_clk();
    check("rel_tick1", {31'd0, Tick}, 32'd1);
    check("rel_bcd", {16'd0, BCD}, 32'h0000);

    // Hold with E=0 for 10 ticks.
    E = 1'b0;
    do_load(16'h0123);
    ticks = 0;
    n = 0;
    while (ticks < 10 && n < 60) begin
      tick_clk();
      n++;
      if (Tick === 1'b1) ticks++;
    end
    check("hold_ticks", ticks, 10);
    check("hold_bcd", {16'd0, BCD}, 32'h0123);
    check("hold_tc", {31'd0, TC}, 32'd0);
`ifdef BCD_SEG7_DECODE_EN
    check("hold_leds0", {25'd0, LEDS[6:0]}, {25'd0, 7'b1111001});
    check("hold_leds1", {25'd0, LEDS[13:7]}, {25'd0, 7'b1101101});
`endif

    // Direction change takes effect on the next step only.
    E = 1'b1; Up = 1'b0;
    wait_tick("dir_wait");
    tick_clk();
    check("dir_down", {16'd0, BCD}, 32'h0122);
`ifdef BCD_SEG7_DECODE_EN
    check("dir_leds0", {25'd0, LEDS[6:0]}, {25'd0, 7'b1101101});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
